clkgate_ctrl: RTL and testbench

//  Sequences the E inputs of N latch-based clock-gate cells (one per clock domain).

---
 rtl/clkgate_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_clkgate_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkgate_ctrl.sv
// -----------------------------------------------------------------------------
// clkgate_ctrl
//   Drives the E pins of N latch-based clock-gate cells, one per clock domain.
//   Each domain has a small OFF -> WAKE -> ON FSM:
//   - A domain wakes when it asks for its clock (req or busy) and the wake
//     arbiter grants it.
//   - It reports ready once its gated clock is usable.
//   - It is gated off again after cfg_idle idle cycles of hysteresis.
//   A round-robin arbiter admits at most one wake per cycle to limit inrush.
//
// Parameters
//   N         number of gated domains (1..16)
//   WAKE_LAT  cycles from en rising to ready rising (>= 1)
//   CW        width of the idle-hysteresis counter and cfg_idle
//
// Ports
//   CK        in   clock (ungated; same clock feeds the gate cells)
//   RN        in   asynchronous reset, active low
//   req       in   [N]  domain i requests its clock
//   busy      in   [N]  domain i has work in flight (blocks gating, forces wake)
//   cfg_idle  in   [CW] idle cycles required before gating, sampled every cycle
//   TE        in   scan/test override forcing every en high
//                  (only present when CLKGATE_CTRL_TEST_EN is defined)
//   en        out  [N]  gate-cell enables, registered
//   ready     out  [N]  gated clock i is running, registered
//   waking    out  a wake sequence is in progress in some domain, registered
//
// Build option
//   CLKGATE_CTRL_TEST_EN : adds TE; en = registered enable OR TE.
// -----------------------------------------------------------------------------
module clkgate_ctrl #(
  parameter int N        = 4,
  parameter int WAKE_LAT = 2,
  parameter int CW       = 8
) (
  input  logic          CK,
  input  logic          RN,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  busy,
  input  logic [CW-1:0] cfg_idle,
`ifdef CLKGATE_CTRL_TEST_EN
  input  logic          TE,
`endif
  output logic [N-1:0]  en,
  output logic [N-1:0]  ready,
  output logic          waking
);

  localparam int              PW        = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0]   WAKE_LOAD = CW'(WAKE_LAT - 1);
  localparam logic [PW-1:0]   LAST_IDX  = PW'(N - 1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2
  } state_t;

  state_t        r_state [N];
  logic [CW-1:0] r_cnt   [N];
  logic [PW-1:0] r_ptr;
  logic [N-1:0]  r_en;
  logic [N-1:0]  r_ready;
  logic          r_waking;

  state_t        w_state_nxt [N];
  logic [CW-1:0] w_cnt_nxt   [N];
  logic [N-1:0]  w_cand;
  logic [N-1:0]  w_gnt;
  logic          w_gnt_any;
  logic [PW-1:0] w_gnt_idx;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW-1:0] w_idx;
  logic [N-1:0]  w_en_nxt;
  logic [N-1:0]  w_ready_nxt;
  logic          w_waking_nxt;

  // Index k positions after base, wrapping at N.
  function automatic logic [PW-1:0] rot_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) begin
      s = s - N;
    end else begin
      s = s;
    end
    return PW'(s);
  endfunction

  // Round-robin wake arbiter: first OFF requester at or after the pointer wins.
  always_comb begin
    w_gnt     = '0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int i = 0; i < N; i++) begin
      w_cand[i] = (r_state[i] == ST_OFF) && (req[i] || busy[i]);
    end
    for (int k = 0; k < N; k++) begin
      w_idx = rot_idx(r_ptr, k);
      if (!w_gnt_any && w_cand[w_idx]) begin
        w_gnt_any        = 1'b1;
        w_gnt_idx        = w_idx;
        w_gnt[w_idx]     = 1'b1;
      end else begin
        w_gnt_any = w_gnt_any;
      end
    end
    if (w_gnt_any) begin
      w_ptr_nxt = (w_gnt_idx == LAST_IDX) ? '0 : (w_gnt_idx + PW'(1));
    end else begin
      w_ptr_nxt = r_ptr;
    end
  end

  // Per-domain next state, hysteresis counter and next registered outputs.
  always_comb begin
    w_waking_nxt = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_OFF: begin
          if (w_gnt[i]) begin
            w_state_nxt[i] = ST_WAKE;
            w_cnt_nxt[i]   = WAKE_LOAD;
          end else begin
            w_cnt_nxt[i]   = '0;
          end
        end
        ST_WAKE: begin
          // A dropped request does not abort the wake; it always completes.
          if (r_cnt[i] == '0) begin
            w_state_nxt[i] = ST_ON;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i]   = r_cnt[i] - CW'(1);
          end
        end
        ST_ON: begin
          if (!req[i] && !busy[i]) begin
            // Equality compare: lowering cfg_idle below the running count
            // keeps the domain on until idle is broken and the count restarts.
            if (r_cnt[i] == cfg_idle) begin
              w_state_nxt[i] = ST_OFF;
              w_cnt_nxt[i]   = '0;
            end else if (r_cnt[i] != CNT_MAX) begin
              w_cnt_nxt[i]   = r_cnt[i] + CW'(1);
            end else begin
              w_cnt_nxt[i]   = r_cnt[i];
            end
          end else begin
            w_cnt_nxt[i] = '0;
          end
        end
        default: begin
          w_state_nxt[i] = ST_OFF;
          w_cnt_nxt[i]   = '0;
        end
      endcase
      w_en_nxt[i]    = (w_state_nxt[i] != ST_OFF);
      w_ready_nxt[i] = (w_state_nxt[i] == ST_ON);
      w_waking_nxt   = w_waking_nxt | (w_state_nxt[i] == ST_WAKE);
    end
  end

  // State, counters, pointer and output flops.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= ST_OFF;
        r_cnt[i]   <= '0;
      end
      r_ptr    <= '0;
      r_en     <= '0;
      r_ready  <= '0;
      r_waking <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_ptr    <= w_ptr_nxt;
      r_en     <= w_en_nxt;
      r_ready  <= w_ready_nxt;
      r_waking <= w_waking_nxt;
    end
  end

`ifdef CLKGATE_CTRL_TEST_EN
  // Test override is combinational so scan can force every gate open at once.
  assign en = r_en | {N{TE}};
`else
  assign en = r_en;
`endif
  assign ready  = r_ready;
  assign waking = r_waking;

endmodule

// File: tb/tb_clkgate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clkgate_ctrl
//   Scoreboard bench for clkgate_ctrl (N=4, WAKE_LAT=2, CW=8). A cycle model
//   pushes the expected en/ready/waking when inputs are driven; the entry is
//   popped and compared one clock edge later. Directed checks pin down the
//   exact latencies and arbitration order independently of the model.
// -----------------------------------------------------------------------------
module tb_clkgate_ctrl;

  localparam int N  = 4;
  localparam int WL = 2;
  localparam int CW = 8;

  logic          CK = 1'b0;
  logic          RN;
  logic [N-1:0]  req;
  logic [N-1:0]  busy;
  logic [CW-1:0] cfg_idle;
  logic [N-1:0]  en;
  logic [N-1:0]  ready;
  logic          waking;
`ifdef CLKGATE_CTRL_TEST_EN
  logic          TE;
`endif

  always #5 CK = ~CK;

  clkgate_ctrl #(.N(N), .WAKE_LAT(WL), .CW(CW)) dut (
    .CK       (CK),
    .RN       (RN),
    .req      (req),
    .busy     (busy),
    .cfg_idle (cfg_idle),
`ifdef CLKGATE_CTRL_TEST_EN
    .TE       (TE),
`endif
    .en       (en),
    .ready    (ready),
    .waking   (waking)
  );

  typedef struct packed {
    logic [N-1:0] en;
    logic [N-1:0] rdy;
    logic         wk;
  } exp_t;

  exp_t sb_q[$];

  // Model: state 0=off 1=waking 2=on, wake countdown / idle run length, rr pointer.
  int m_st  [N];
  int m_cnt [N];
  int m_ptr;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i]  = 0;
      m_cnt[i] = 0;
    end
    m_ptr = 0;
    sb_q.delete();
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  function automatic void model_step();
    int   g;
    int   d;
    exp_t e;
    g = -1;
    for (int k = 0; k < N; k++) begin
      d = (m_ptr + k) % N;
      if (g < 0 && m_st[d] == 0 && (req[d] || busy[d])) g = d;
    end
    if (g >= 0) m_ptr = (g + 1) % N;
    for (int i = 0; i < N; i++) begin
      case (m_st[i])
        0: if (i == g) begin m_st[i] = 1; m_cnt[i] = WL - 1; end
        1: if (m_cnt[i] == 0) m_st[i] = 2; else m_cnt[i] = m_cnt[i] - 1;
        2: begin
          if (!req[i] && !busy[i]) begin
            if (m_cnt[i] == int'(cfg_idle)) begin m_st[i] = 0; m_cnt[i] = 0; end
            else if (m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
          end else begin
            m_cnt[i] = 0;
          end
        end
        default: m_st[i] = 0;
      endcase
    end
    e = '0;
    for (int i = 0; i < N; i++) begin
      e.en[i]  = (m_st[i] != 0);
      e.rdy[i] = (m_st[i] == 2);
      e.wk     = e.wk | (m_st[i] == 1);
    end
    sb_q.push_back(e);
  endfunction

  // One clock: predict, let the edge happen, then compare 1 time unit later.
  task automatic cycle(input string tag);
    exp_t e;
    model_step();
    @(posedge CK);
    #1;
    e = sb_q.pop_front();
    chk({tag, "_en"},     32'(en),     32'(e.en));
    chk({tag, "_ready"},  32'(ready),  32'(e.rdy));
    chk({tag, "_waking"}, 32'(waking), 32'(e.wk));
  endtask

  // Assert reset asynchronously and check outputs clear before any edge.
  task automatic do_reset(input string tag);
    RN = 1'b0;
    model_reset();
    #2;
    chk({tag, "_en"},     32'(en),     32'd0);
    chk({tag, "_ready"},  32'(ready),  32'd0);
    chk({tag, "_waking"}, 32'(waking), 32'd0);
    @(posedge CK);
    @(posedge CK);
    #1;
    RN = 1'b1;
  endtask

  initial begin
    RN       = 1'b0;
    req      = '0;
    busy     = '0;
    cfg_idle = 8'd3;
`ifdef CLKGATE_CTRL_TEST_EN
    TE       = 1'b0;
`endif
    do_reset("rst0");

    // Uncontested wake of domain 1: en next cycle, ready WAKE_LAT later.
    req[1] = 1'b1;
    cycle("w1");
    chk("w1_en1", 32'(en[1]), 32'd1);
    chk("w1_wk",  32'(waking), 32'd1);
    cycle("w2");
    chk("w2_rdy1", 32'(ready[1]), 32'd0);
    chk("w2_wk",   32'(waking),   32'd1);
    cycle("w3");
    chk("w3_rdy1", 32'(ready[1]), 32'd1);
    chk("w3_wk",   32'(waking),   32'd0);
    cycle("w4");

    // Idle hysteresis with cfg_idle=3: gated 4 cycles after idle begins.
    req[1] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cycle("h");
      chk("h_en1_hold", 32'(en[1]), 32'd1);
    end
    cycle("h_off");
    chk("h_en1_off",  32'(en[1]),    32'd0);
    chk("h_rdy1_off", 32'(ready[1]), 32'd0);

    // Re-wake, then break idle with a pulse: counting restarts.
    req[1] = 1'b1;
    for (int j = 0; j < 3; j++) cycle("p_wake");
    req[1] = 1'b0;
    cycle("p_idle");
    cycle("p_idle");
    req[1] = 1'b1;
    cycle("p_pulse");
    req[1] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cycle("p");
      chk("p_en1_hold", 32'(en[1]), 32'd1);
    end
    cycle("p_off");
    chk("p_en1_off", 32'(en[1]), 32'd0);

    // All four request at once from reset: one admitted per cycle, 0..3.
    do_reset("rst1");
    cfg_idle = 8'd0;
    req      = 4'b1111;
    begin
      logic [N-1:0] exp_en;
      exp_en = 4'b0000;
      for (int k = 0; k < N; k++) begin
        cycle("rr");
        exp_en[k] = 1'b1;
        chk("rr_order", 32'(en), 32'(exp_en));
      end
    end
    for (int j = 0; j < 3; j++) cycle("rr_settle");
    chk("rr_all_rdy", 32'(ready), 32'hF);
    req = 4'b0000;
    cycle("rr_off");
    chk("rr_off_cfg0", 32'(en), 32'd0);
    // Pointer wrapped back to 0: domain 0 wins over 3.
    req = 4'b1001;
    cycle("rr_wrap");
    chk("rr_wrap_d0", 32'(en), 32'h1);
    req = 4'b0000;
    for (int j = 0; j < 6; j++) cycle("rr_drain");

    // Reset while domain 2 is mid-wake.
    req[2] = 1'b1;
    cycle("mw");
    chk("mw_wk", 32'(waking), 32'd1);
    do_reset("mw_rst");
    req = '0;

    // busy alone wakes a domain and holds it; gates cfg_idle+1 after busy falls.
    cfg_idle = 8'd2;
    busy[2]  = 1'b1;
    for (int j = 0; j < 6; j++) cycle("b");
    chk("b_rdy2", 32'(ready[2]), 32'd1);
    busy[2] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      cycle("b_idle");
      chk("b_en2_hold", 32'(en[2]), 32'd1);
    end
    cycle("b_off");
    chk("b_en2_off", 32'(en[2]), 32'd0);

    // cfg_idle lowered below the running count: counter saturates, stays on.
    cfg_idle = 8'd10;
    req[0]   = 1'b1;
    for (int j = 0; j < 4; j++) cycle("s_wake");
    req[0] = 1'b0;
    for (int j = 0; j < 5; j++) cycle("s_idle");
    cfg_idle = 8'd2;
    for (int j = 0; j < 260; j++) cycle("s_sat");
    chk("s_still_on", 32'(ready[0]), 32'd1);
    req[0] = 1'b1;
    cycle("s_brk");
    req[0] = 1'b0;
    for (int j = 0; j < 3; j++) cycle("s_recount");
    chk("s_off", 32'(en[0]), 32'd0);

    // Randomised traffic against the model.
    for (int j = 0; j < 600; j++) begin
      req  = 4'($urandom);
      busy = 4'($urandom) & 4'($urandom);
      if ((j % 37) == 0) cfg_idle = 8'($urandom_range(0, 5));
      cycle("rnd");
    end
    req  = '0;
    busy = '0;
    for (int j = 0; j < 20; j++) cycle("rnd_drain");
    chk("rnd_all_off", 32'(en), 32'd0);

`ifdef CLKGATE_CTRL_TEST_EN
    TE = 1'b1;
    #1;
    chk("te_en",  32'(en),    32'hF);
    chk("te_rdy", 32'(ready), 32'd0);
    TE = 1'b0;
    #1;
    chk("te_off", 32'(en),    32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
